tile_draw: RTL and testbench
============================

TILE_DRAW -- requirements
Module: tile_draw

Interface
REQ-001 SHALL have parameter X_BASE, default 120, meaning left x of the playfield.
REQ-002 SHALL have parameter TILE_W, default 20, meaning lane/tile width in pixels (4 lanes span X_BASE..X_BASE+79).
REQ-003 SHALL have parameter TILE_H, default 60, meaning tile height in pixels.
REQ-004 SHALL have parameter Y_MAX, default 239, meaning last visible row.
REQ-005 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request to draw one tile; sampled only in IDLE.
REQ-008 SHALL have port lane  input  2  lane index 0..3.
REQ-009 SHALL have port y_top  input  8  top row of the tile.
REQ-010 SHALL have port fill  input  3  tile fill colour.
REQ-011 SHALL have port x  output  9  pixel x to the VGA adapter.
REQ-012 SHALL have port y  output  8  pixel y to the VGA adapter.
REQ-013 SHALL have port colour  output  3  pixel colour.
REQ-014 SHALL have port plot  output  1  pixel write enable for x/y/colour.
REQ-015 SHALL have port busy  output  1  high from acceptance of start until done.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DRAW, FIN; all outputs registered.
REQ-018 IDLE: start=1 at an edge SHALL latch lane, y_top, fill, set busy=1, and go to LOAD.
REQ-019 LOAD SHALL compute x0 = X_BASE + lane*TILE_W and row = y_top (9-bit), go to DRAW; plot=0.
REQ-020 DRAW SHALL emit one pixel per cycle with plot=1, raster order, x inner loop x0..x0+TILE_W-1, then row+1.
REQ-021 Row arithmetic SHALL be 9 bits wide so y_top+TILE_H-1 above 255 never wraps.
REQ-022 Rows with row > Y_MAX SHALL NOT be plotted; DRAW SHALL go to FIN when row reaches TILE_H past y_top or exceeds Y_MAX, whichever is first.
REQ-023 y_top > Y_MAX SHALL go LOAD -> FIN with zero plots.
REQ-024 FIN SHALL hold done=1, busy=0, plot=0 for exactly one cycle, then return to IDLE.
REQ-025 Timing: start sampled at edge 0; first plot valid after edge 2; unclipped tile has 1200 plots (after edges 2..1201); done after edge 1202.
REQ-026 start while busy SHALL be ignored and not queued; a new tile is accepted in IDLE, earliest the cycle after done.
REQ-027 Latched inputs SHALL be stable while busy; changes on lane/y_top/fill mid-draw SHALL have no effect.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0.
REQ-029 Reset mid-DRAW SHALL abort the tile with no done pulse; drawing resumes only on a fresh start.

Configuration
REQ-030 Macro TILE_BORDER_EN: when defined, pixels at column offset 0 or TILE_W-1, or row offset 0 or TILE_H-1, SHALL be colour 3'b000, others fill.
REQ-031 Without TILE_BORDER_EN every plotted pixel SHALL be fill; pixel count and timing SHALL be identical in both builds.

Verification
REQ-032 lane=0, y_top=0, fill=3'b010 -> 1200 plots, x 120..139, y 0..59, done one cycle after edge 1202, busy low thereafter.
REQ-033 lane=3, y_top=200 -> 800 plots, x 180..199, y 200..239, no y>239, done follows last plot by one cycle.
REQ-034 y_top=240, any lane -> zero plots, done after edge 2.
REQ-035 start pulsed at cycle 100 of a draw with different lane -> ignored; only the first tile drawn, one done.
REQ-036 resetn low at cycle 500 of a draw -> all outputs 0 asynchronously, no done; subsequent start draws full tile normally.
REQ-037 TILE_BORDER_EN build, lane=1, y_top=10, fill=3'b111 -> x=140/159 and y=10/69 pixels black, interior white, still 1200 plots.

Source files
------------

// File: rtl/tile_draw.sv
// rtl/tile_draw.sv - raster-fills one rectangular tile into a VGA pixel-write port
//
// Purpose
//   On a start request in IDLE the block latches lane / y_top / fill and then
//   streams one pixel per clock (x inner loop, then next row) covering a
//   TILE_W x TILE_H rectangle whose left edge is X_BASE + lane*TILE_W and whose
//   top row is y_top. Rows below Y_MAX are clipped. A single-cycle done pulse
//   ends every accepted tile. All outputs are registered.
//
// Optional feature
//   TILE_BORDER_EN : when defined, the outermost ring of the tile (first/last
//                    column, first/last row) is drawn black (3'b000) and the
//                    interior in the fill colour. Pixel count and timing are
//                    the same in both builds.
//
// Ports
//   clock   in   1  sole clock, rising edge
//   resetn  in   1  asynchronous active-low reset
//   start   in   1  draw request, only sampled in IDLE
//   lane    in   2  lane index 0..3
//   y_top   in   8  top row of the tile
//   fill    in   3  fill colour
//   x       out  9  pixel x
//   y       out  8  pixel y
//   colour  out  3  pixel colour
//   plot    out  1  pixel write enable
//   busy    out  1  high from acceptance of start until done
//   done    out  1  one-cycle completion pulse

module tile_draw #(
    parameter int X_BASE = 120,
    parameter int TILE_W = 20,
    parameter int TILE_H = 60,
    parameter int Y_MAX  = 239
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] lane,
    input  logic [7:0] y_top,
    input  logic [2:0] fill,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // All geometry is carried in 9 bits so a tile that hangs below row 255
    // keeps counting upward instead of wrapping back to the top of the screen.
    localparam logic [8:0] LP_X_BASE    = 9'(X_BASE);
    localparam logic [8:0] LP_TILE_W    = 9'(TILE_W);
    localparam logic [8:0] LP_COL_LAST  = 9'(TILE_W - 1);
    localparam logic [8:0] LP_ROFF_LAST = 9'(TILE_H - 1);
    localparam logic [8:0] LP_Y_MAX     = 9'(Y_MAX);

    state_t     r_state;
    state_t     w_state_nxt;

    // Latched request
    logic [1:0] r_lane;
    logic [7:0] r_ytop;
    logic [2:0] r_fill;
    logic [1:0] w_lane_nxt;
    logic [7:0] w_ytop_nxt;
    logic [2:0] w_fill_nxt;

    // Raster walk state
    logic [8:0] r_x0;
    logic [8:0] r_row;
    logic [8:0] r_col;
    logic [8:0] r_roff;
    logic [8:0] w_x0_nxt;
    logic [8:0] w_row_nxt;
    logic [8:0] w_col_nxt;
    logic [8:0] w_roff_nxt;

    // Registered outputs
    logic [8:0] r_x;
    logic [7:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;
    logic [8:0] w_x_nxt;
    logic [7:0] w_y_nxt;
    logic [2:0] w_colour_nxt;
    logic       w_plot_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    // Datapath helpers
    logic [8:0] w_x0_calc;
    logic [8:0] w_ytop9;
    logic       w_col_last;
    logic       w_row_last;
    logic [2:0] w_pix_colour;

    assign w_x0_calc  = LP_X_BASE + 9'(r_lane) * LP_TILE_W;
    assign w_ytop9    = {1'b0, r_ytop};
    assign w_col_last = (r_col == LP_COL_LAST);
    // The current row is the last one drawn either because the tile is
    // complete or because the next row would fall off the bottom.
    assign w_row_last = (r_roff == LP_ROFF_LAST) || (r_row >= LP_Y_MAX);

`ifdef TILE_BORDER_EN
    logic w_on_border;
    assign w_on_border  = (r_col == 9'd0) || w_col_last ||
                          (r_roff == 9'd0) || (r_roff == LP_ROFF_LAST);
    assign w_pix_colour = w_on_border ? 3'b000 : r_fill;
`else
    assign w_pix_colour = r_fill;
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_ytop_nxt   = r_ytop;
        w_fill_nxt   = r_fill;
        w_x0_nxt     = r_x0;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_roff_nxt   = r_roff;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lane_nxt  = lane;
                    w_ytop_nxt  = y_top;
                    w_fill_nxt  = fill;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                w_x0_nxt   = w_x0_calc;
                w_row_nxt  = w_ytop9;
                w_col_nxt  = 9'd0;
                w_roff_nxt = 9'd0;
                // A tile starting below the visible area produces no pixels.
                if (w_ytop9 > LP_Y_MAX) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end

            S_DRAW: begin
                w_plot_nxt   = 1'b1;
                w_x_nxt      = r_x0 + r_col;
                w_y_nxt      = r_row[7:0];
                w_colour_nxt = w_pix_colour;
                if (w_col_last) begin
                    w_col_nxt  = 9'd0;
                    w_row_nxt  = r_row + 9'd1;
                    w_roff_nxt = r_roff + 9'd1;
                    // Leave on the edge that emits the final pixel so done
                    // lands exactly one cycle after the last plot.
                    if (w_row_last) begin
                        w_state_nxt = S_FIN;
                    end
                end else begin
                    w_col_nxt = r_col + 9'd1;
                end
            end

            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lane   <= 2'd0;
            r_ytop   <= 8'd0;
            r_fill   <= 3'd0;
            r_x0     <= 9'd0;
            r_row    <= 9'd0;
            r_col    <= 9'd0;
            r_roff   <= 9'd0;
            r_x      <= 9'd0;
            r_y      <= 8'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_lane   <= w_lane_nxt;
            r_ytop   <= w_ytop_nxt;
            r_fill   <= w_fill_nxt;
            r_x0     <= w_x0_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_roff   <= w_roff_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_tile_draw.sv
// tb/tb_tile_draw.sv - self-checking bench for tile_draw

module tb_tile_draw;

    localparam int X_BASE = 120;
    localparam int TILE_W = 20;
    localparam int TILE_H = 60;
    localparam int Y_MAX  = 239;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] lane;
    logic [7:0] y_top;
    logic [2:0] fill;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_mis;

    // expected pixel {x[8:0], y[7:0], colour[2:0]}
    logic [19:0] sb[$];

    tile_draw #(
        .X_BASE(X_BASE),
        .TILE_W(TILE_W),
        .TILE_H(TILE_H),
        .Y_MAX (Y_MAX)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .lane  (lane),
        .y_top (y_top),
        .fill  (fill),
        .x     (x),
        .y     (y),
        .colour(colour),
        .plot  (plot),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Push every pixel the tile should produce, in raster order.
    task automatic build_expected(input logic [1:0] l, input logic [7:0] yt, input logic [2:0] f);
        int         x0;
        int         row;
        logic [2:0] c;
        sb.delete();
        x0 = X_BASE + int'(l) * TILE_W;
        for (int r = 0; r < TILE_H; r++) begin
            row = int'(yt) + r;
            if (row > Y_MAX) break;
            for (int cc = 0; cc < TILE_W; cc++) begin
`ifdef TILE_BORDER_EN
                c = (cc == 0 || cc == TILE_W - 1 || r == 0 || r == TILE_H - 1) ? 3'b000 : f;
`else
                c = f;
`endif
                sb.push_back({9'(x0 + cc), 8'(row), c});
            end
        end
    endtask

    // inj_kind: 0 none, 1 start pulse + input changes at inj_cycle, 2 reset at inj_cycle
    task automatic run_tile(input string name, input logic [1:0] l, input logic [7:0] yt,
                            input logic [2:0] f, input int inj_cycle, input int inj_kind);
        int          nplots;
        int          exp_done;
        int          first_plot;
        int          done_cnt;
        int          done_edge;
        bit          aborted;
        logic [19:0] e;
        logic [19:0] a;
        build_expected(l, yt, f);
        nplots     = sb.size();
        exp_done   = 2 + nplots;
        first_plot = -1;
        done_cnt   = 0;
        done_edge  = -1;
        aborted    = 1'b0;

        @(negedge clock);
        lane  = l;
        y_top = yt;
        fill  = f;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end

        for (int n = 1; n <= 2000; n++) begin
            if (inj_kind == 1 && n == inj_cycle) begin
                lane  = l + 2'd1;
                y_top = yt + 8'd5;
                fill  = ~f;
                start = 1'b1;
            end
            @(posedge clock);
            if (inj_kind == 2 && n == inj_cycle) begin
                #2;
                resetn = 1'b0;
                #1;
                n_cmp++;
                if ({x, y, colour, plot, busy, done} !== 25'd0) begin
                    n_mis++;
                    $display("FAIL %s async_reset_outputs: got x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
                             name, x, y, colour, plot, busy, done);
                end
                repeat (3) begin
                    @(posedge clock);
                    #1;
                    if (done === 1'b1) done_cnt++;
                end
                sb.delete();
                @(negedge clock);
                resetn  = 1'b1;
                aborted = 1'b1;
                break;
            end
            #1;
            start = 1'b0;
            if (plot === 1'b1) begin
                if (first_plot < 0) first_plot = n;
                a = {x, y, colour};
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL %s extra_plot edge %0d: got x=%0d y=%0d c=%0d want no plot",
                             name, n, x, y, colour);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        n_mis++;
                        $display("FAIL %s pixel edge %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                 name, n, a[19:11], a[10:3], a[2:0], e[19:11], e[10:3], e[2:0]);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = n;
                n_cmp++;
                if (busy !== 1'b0 || plot !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s done_cycle_flags: got busy=%b plot=%b want 0 0", name, busy, plot);
                end
            end
            if (done_edge >= 0 && n >= done_edge + 20) break;
        end

        if (aborted) begin
            n_cmp++;
            if (done_cnt != 0) begin
                n_mis++;
                $display("FAIL %s done_after_reset: got %0d pulses want 0", name, done_cnt);
            end
        end else begin
            n_cmp++;
            if (sb.size() != 0) begin
                n_mis++;
                $display("FAIL %s missing_plots: got %0d want %0d", name, nplots - sb.size(), nplots);
            end
            n_cmp++;
            if (done_cnt != 1) begin
                n_mis++;
                $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
            end
            n_cmp++;
            if (done_edge != exp_done) begin
                n_mis++;
                $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, exp_done);
            end
            if (nplots > 0) begin
                n_cmp++;
                if (first_plot != 2) begin
                    n_mis++;
                    $display("FAIL %s first_plot_edge: got %0d want 2", name, first_plot);
                end
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_mis++;
                $display("FAIL %s busy_after_done: got %b want 0", name, busy);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        lane   = 2'd0;
        y_top  = 8'd0;
        fill   = 3'd0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({x, y, colour, plot, busy, done} !== 25'd0) begin
            n_mis++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
                     x, y, colour, plot, busy, done);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_without_start: got plot=%b busy=%b want 0 0", plot, busy);
        end
    endtask

    task automatic test_full_tile();
        run_tile("full_tile", 2'd0, 8'd0, 3'b010, 0, 0);
    endtask

    task automatic test_clip_bottom();
        run_tile("clip_bottom", 2'd3, 8'd200, 3'b101, 0, 0);
    endtask

    task automatic test_clip_all();
        run_tile("clip_all", 2'd2, 8'd240, 3'b011, 0, 0);
    endtask

    task automatic test_start_while_busy();
        run_tile("start_busy", 2'd1, 8'd40, 3'b110, 100, 1);
    endtask

    task automatic test_reset_mid_draw();
        run_tile("reset_mid", 2'd2, 8'd50, 3'b001, 500, 2);
        run_tile("after_reset", 2'd2, 8'd30, 3'b100, 0, 0);
    endtask

    task automatic test_border_tile();
        run_tile("border_tile", 2'd1, 8'd10, 3'b111, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_tile("b2b_first", 2'd3, 8'd100, 3'b010, 0, 0);
        run_tile("b2b_second", 2'd0, 8'd220, 3'b101, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_full_tile();
        test_clip_bottom();
        test_clip_all();
        test_start_while_busy();
        test_reset_mid_draw();
        test_border_tile();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
